// File: rtl/muldiv_hilo_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
// The master side is the pipeline; the slave side is muldiv_hilo_ctrl.
interface muldiv_hilo_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] src_a_i;
    logic [WIDTH-1:0] src_b_i;
    logic             flush_i;
    logic             wr_hi_i;
    logic             wr_lo_i;
    logic [WIDTH-1:0] wr_data_i;
    logic             rd_hilo_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             done_o;
    logic             stall_o;

    modport master (
        output start_i, op_i, src_a_i, src_b_i, flush_i,
        output wr_hi_i, wr_lo_i, wr_data_i, rd_hilo_i,
        input  hi_o, lo_o, busy_o, done_o, stall_o
    );

    modport slave (
        input  start_i, op_i, src_a_i, src_b_i, flush_i,
        input  wr_hi_i, wr_lo_i, wr_data_i, rd_hilo_i,
        output hi_o, lo_o, busy_o, done_o, stall_o
    );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO: shared shift-add / restoring-divide
// datapath, WIDTH cycles per op. Define MULDIV_FAST_MULT_EN for single-cycle multiplies.
module muldiv_hilo_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    muldiv_hilo_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic neg, input logic [WIDTH-1:0] v);
        cond_neg_w = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_d(input logic neg, input logic [2*WIDTH-1:0] v);
        cond_neg_d = neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             is_div_r;
    logic             neg_q_r;
    logic             neg_rem_r;
    logic             div0_r;
    logic [WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic [WIDTH-1:0] a_abs_s;
    logic [WIDTH-1:0] b_abs_s;
    logic             calc_go_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH-1:0] rem_sh_s;
    logic             rem_ge_s;
    logic [WIDTH-1:0] step_hi_s;
    logic [WIDTH-1:0] step_lo_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    // Operand magnitudes and start qualification for the iterative path
    always_comb begin
        a_neg_s   = ~bus.op_i[0] & bus.src_a_i[WIDTH-1];
        b_neg_s   = ~bus.op_i[0] & bus.src_b_i[WIDTH-1];
        a_abs_s   = cond_neg_w(a_neg_s, bus.src_a_i);
        b_abs_s   = cond_neg_w(b_neg_s, bus.src_b_i);
        calc_go_s = 1'b0;
        if ((state_r == ST_IDLE) && bus.start_i && !bus.flush_i) begin
`ifdef MULDIV_FAST_MULT_EN
            calc_go_s = bus.op_i[1];
`else
            calc_go_s = 1'b1;
`endif
        end else begin
            calc_go_s = 1'b0;
        end
    end

`ifdef MULDIV_FAST_MULT_EN
    logic               fast_go_s;
    logic [2*WIDTH-1:0] fast_a_s;
    logic [2*WIDTH-1:0] fast_b_s;
    logic [2*WIDTH-1:0] fast_prod_s;

    // Single-cycle multiply: sign-extend for MULT, zero-extend for MULTU
    always_comb begin
        fast_go_s   = (state_r == ST_IDLE) && bus.start_i && !bus.flush_i && !bus.op_i[1];
        fast_a_s    = {{WIDTH{a_neg_s}}, bus.src_a_i};
        fast_b_s    = {{WIDTH{b_neg_s}}, bus.src_b_i};
        fast_prod_s = fast_a_s * fast_b_s;
    end
`endif

    // One datapath step: acc_hi holds partial product / remainder, acc_lo multiplier / quotient
    always_comb begin
        mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        rem_sh_s  = {acc_hi_r[WIDTH-2:0], acc_lo_r[WIDTH-1]};
        rem_ge_s  = acc_hi_r[WIDTH-1] | (rem_sh_s >= opnd_r);
        if (!is_div_r) begin
            step_hi_s = mul_sum_s[WIDTH:1];
            step_lo_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
        end else if (rem_ge_s) begin
            step_hi_s = rem_sh_s - opnd_r;
            step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
        end else begin
            step_hi_s = rem_sh_s;
            step_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up of the final step; a zero divisor leaves an all-ones quotient
    always_comb begin
        prod_fix_s = cond_neg_d(neg_q_r, {step_hi_s, step_lo_s});
        if (is_div_r) begin
            res_hi_s = cond_neg_w(neg_rem_r, step_hi_s);
            res_lo_s = div0_r ? {WIDTH{1'b1}} : cond_neg_w(neg_q_r, step_lo_s);
        end else begin
            res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_fix_s[WIDTH-1:0];
        end
    end

    // Sequencer FSM, datapath registers and HI/LO ownership
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            is_div_r  <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_rem_r <= 1'b0;
            div0_r    <= 1'b0;
            opnd_r    <= {WIDTH{1'b0}};
            acc_hi_r  <= {WIDTH{1'b0}};
            acc_lo_r  <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                    if (bus.wr_hi_i) hi_r <= bus.wr_data_i;
                    if (bus.wr_lo_i) lo_r <= bus.wr_data_i;
`ifdef MULDIV_FAST_MULT_EN
                    if (fast_go_s) begin
                        hi_r   <= fast_prod_s[2*WIDTH-1:WIDTH];
                        lo_r   <= fast_prod_s[WIDTH-1:0];
                        done_r <= 1'b1;
                    end
`endif
                    if (calc_go_s) begin
                        is_div_r  <= bus.op_i[1];
                        neg_q_r   <= a_neg_s ^ b_neg_s;
                        neg_rem_r <= a_neg_s;
                        div0_r    <= bus.op_i[1] && (bus.src_b_i == {WIDTH{1'b0}});
                        opnd_r    <= bus.op_i[1] ? b_abs_s : a_abs_s;
                        acc_hi_r  <= {WIDTH{1'b0}};
                        acc_lo_r  <= bus.op_i[1] ? a_abs_s : b_abs_s;
                        cnt_r     <= {CNT_W{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (bus.flush_i) begin
                        busy_r  <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        acc_hi_r <= step_hi_s;
                        acc_lo_r <= step_lo_s;
                        cnt_r    <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_CNT) begin
                            hi_r    <= res_hi_s;
                            lo_r    <= res_lo_s;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.hi_o    = hi_r;
    assign bus.lo_o    = lo_r;
    assign bus.busy_o  = busy_r;
    assign bus.done_o  = done_r;
    assign bus.stall_o = busy_r & (bus.start_i | bus.rd_hilo_i | bus.wr_hi_i | bus.wr_lo_i);
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: directed and random ops against a
// 64-bit arithmetic reference model, plus hazard, flush and reset scenarios.
module tb_muldiv_hilo_ctrl;
    logic clk;
    logic resetn;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] exp_v;

    muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();

    muldiv_hilo_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: {HI, LO} from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'd0;
        case (op)
            2'b00: begin p = sa * sb; model = p; end
            2'b01: model = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; model = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else model = {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int calc_cycles(input logic [1:0] op);
        calc_cycles = 32;
`ifdef MULDIV_FAST_MULT_EN
        if (op[1] == 1'b0) calc_cycles = 0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        exp_v = model(op, a, b);
        n = calc_cycles(op);
        bus.op_i = op; bus.src_a_i = a; bus.src_b_i = b; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.op_i = 2'($urandom_range(0, 3)); bus.src_a_i = $urandom; bus.src_b_i = $urandom;
        for (int c = 1; c <= n + 1; c++) begin
            if (c > 1) tick();
            check("busy", 64'(bus.busy_o), 64'(c <= n));
            check("done", 64'(bus.done_o), 64'(c == n + 1));
        end
        check("hi", 64'(bus.hi_o), 64'(exp_v[63:32]));
        check("lo", 64'(bus.lo_o), 64'(exp_v[31:0]));
        m_hi = exp_v[63:32];
        m_lo = exp_v[31:0];
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        resetn = 1'b0;
        bus.start_i = 1'b0; bus.op_i = 2'b00; bus.src_a_i = 32'd0; bus.src_b_i = 32'd0;
        bus.flush_i = 1'b0; bus.wr_hi_i = 1'b0; bus.wr_lo_i = 1'b0; bus.wr_data_i = 32'd0;
        bus.rd_hilo_i = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(bus.hi_o), 64'd0);
        check("rst_lo", 64'(bus.lo_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        resetn = 1'b1;
        tick();

        // Directed arithmetic cases
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op(2'b11, 32'h8000_0000, 32'h0000_0003);
        run_op(2'b11, 32'h0000_000A, 32'h0000_0000);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: r_b = 32'($urandom_range(1, 7));
                2: r_b = 32'hFFFF_FFFF;
                default: r_b = 32'($urandom);
            endcase
            run_op(r_op, r_a, r_b);
        end

        // MTHI / MTLO in IDLE, one-edge latency
        bus.wr_hi_i = 1'b1; bus.wr_data_i = 32'h1234_5678;
        tick();
        bus.wr_hi_i = 1'b0;
        check("mthi_hi", 64'(bus.hi_o), 64'h1234_5678);
        check("mthi_lo", 64'(bus.lo_o), 64'(m_lo));
        bus.wr_hi_i = 1'b1; bus.wr_lo_i = 1'b1; bus.wr_data_i = 32'hA5A5_0F0F;
        tick();
        bus.wr_hi_i = 1'b0; bus.wr_lo_i = 1'b0;
        check("mtboth_hi", 64'(bus.hi_o), 64'hA5A5_0F0F);
        check("mtboth_lo", 64'(bus.lo_o), 64'hA5A5_0F0F);
        m_hi = 32'hA5A5_0F0F; m_lo = 32'hA5A5_0F0F;

        // Hazards during CALC: MFHI/MTHI held from cycle 2, stray start in cycle 3
        exp_v = model(2'b11, 32'hDEAD_0001, 32'h0000_0007);
        bus.op_i = 2'b11; bus.src_a_i = 32'hDEAD_0001; bus.src_b_i = 32'h0000_0007; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        #1;
        check("haz_stall_c1", 64'(bus.stall_o), 64'd0);
        for (int c = 2; c <= 33; c++) begin
            tick();
            bus.rd_hilo_i = 1'b1; bus.wr_hi_i = 1'b1; bus.wr_data_i = 32'hBEEF_CAFE;
            bus.start_i = (c == 3);
            bus.op_i = 2'b00; bus.src_a_i = 32'h0000_0003; bus.src_b_i = 32'h0000_0003;
            #1;
            check("haz_stall", 64'(bus.stall_o), 64'(c <= 32));
        end
        check("haz_done", 64'(bus.done_o), 64'd1);
        check("haz_hi", 64'(bus.hi_o), 64'(exp_v[63:32]));
        check("haz_lo", 64'(bus.lo_o), 64'(exp_v[31:0]));
        bus.rd_hilo_i = 1'b0; bus.wr_hi_i = 1'b0; bus.start_i = 1'b0;
        m_hi = exp_v[63:32]; m_lo = exp_v[31:0];
        tick();
        check("haz_idle_busy", 64'(bus.busy_o), 64'd0);
        check("haz_idle_done", 64'(bus.done_o), 64'd0);
        check("haz_keep_hi", 64'(bus.hi_o), 64'(m_hi));

        // Flush at cycle 10
        bus.op_i = 2'b10; bus.src_a_i = 32'($urandom); bus.src_b_i = 32'h0000_0013; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        check("fl_busy_c10", 64'(bus.busy_o), 64'd1);
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        check("fl_busy", 64'(bus.busy_o), 64'd0);
        check("fl_hi", 64'(bus.hi_o), 64'(m_hi));
        check("fl_lo", 64'(bus.lo_o), 64'(m_lo));
        for (int c = 0; c < 30; c++) begin
            check("fl_nodone", 64'(bus.done_o), 64'd0);
            tick();
        end
        check("fl_hi_end", 64'(bus.hi_o), 64'(m_hi));

        // start together with flush in IDLE: nothing starts
        bus.op_i = 2'b00; bus.src_a_i = 32'h0000_0009; bus.src_b_i = 32'h0000_0009;
        bus.start_i = 1'b1; bus.flush_i = 1'b1;
        tick();
        bus.start_i = 1'b0; bus.flush_i = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            check("sf_busy", 64'(bus.busy_o), 64'd0);
            check("sf_done", 64'(bus.done_o), 64'd0);
            tick();
        end
        check("sf_hi", 64'(bus.hi_o), 64'(m_hi));
        check("sf_lo", 64'(bus.lo_o), 64'(m_lo));

        // Asynchronous reset mid-CALC
        bus.op_i = 2'b11; bus.src_a_i = 32'hFFFF_0000; bus.src_b_i = 32'h0000_0005; bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        resetn = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_hi", 64'(bus.hi_o), 64'd0);
        check("arst_lo", 64'(bus.lo_o), 64'd0);
        check("arst_done", 64'(bus.done_o), 64'd0);
        tick();
        resetn = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        tick();
        check("arst_done_after", 64'(bus.done_o), 64'd0);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        run_op(2'b11, 32'($urandom), 32'($urandom_range(1, 1000)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
